meas_hex_uart: RTL and testbench

Serial output stage for the time-to-digital converter. It takes one 40-bit measurement word per handshake and transmits it over the FTDI UART as a human-readable line: 10 uppercase ASCII hex digits, MSB nibble first, followed by CR LF, using 8N1 framing. It sits directly downstream of the rate-limited measurement buffer in the top level and drives the `uart_tx` pin.

---
 rtl/meas_hex_uart.sv | 174 +++++++++++++++++
 tb/tb_meas_hex_uart.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/meas_hex_uart.sv
// meas_hex_uart: turns one 40-bit measurement word into an ASCII hex line
// ("XXXXXXXXXX\r\n", MSB nibble first) and sends it as 8N1 serial data.
module meas_hex_uart #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] data,
    input  logic        data_valid,
    output logic        tx,
    output logic        busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // A bit period shorter than two clocks cannot be counted by this datapath.
    if (CLKS_PER_BIT < 2) begin : g_baud_check
        $error("meas_hex_uart: CLK_FREQ / BAUD must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Uppercase ASCII for one hex nibble ('A' - 10 = 0x37).
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] res;
        if (nib < 4'd10) begin
            res = 8'h30 + {4'h0, nib};
        end else begin
            res = 8'h37 + {4'h0, nib};
        end
        return res;
    endfunction

    // Byte for character slot idx; word holds the current nibble in [39:36].
    function automatic logic [7:0] char_byte(input logic [3:0] idx, input logic [39:0] word);
        logic [7:0] res;
        case (idx)
            4'd10:   res = 8'h0D;
            4'd11:   res = 8'h0A;
            default: res = hex_ascii(word[39:36]);
        endcase
        return res;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_r, bit_s;
    logic [3:0]       char_r, char_s;
    logic [39:0]      word_r, word_s;
    logic [7:0]       byte_r, byte_s;
    logic             tx_r, tx_s;
    logic             busy_r, busy_s;
    logic [39:0]      word_shift_s;

    assign word_shift_s = {word_r[35:0], 4'h0};
    assign tx           = tx_r;
    assign busy         = busy_r;

    // State, counters, holding registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            char_r  <= 4'd0;
            word_r  <= 40'h0;
            byte_r  <= 8'h00;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            char_r  <= char_s;
            word_r  <= word_s;
            byte_r  <= byte_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
        end
    end

    // Next-state logic; tx/busy are computed one cycle ahead so they leave registered.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        char_s  = char_r;
        word_s  = word_r;
        byte_s  = byte_r;
        tx_s    = tx_r;
        busy_s  = busy_r;
        case (state_r)
            ST_IDLE: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
                if (data_valid) begin
                    word_s  = data;
                    char_s  = 4'd0;
                    byte_s  = char_byte(4'd0, data);
                    cnt_s   = '0;
                    bit_s   = 3'd0;
                    tx_s    = 1'b0;
                    busy_s  = 1'b1;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    bit_s   = 3'd0;
                    tx_s    = byte_r[0];
                    state_s = ST_DATA;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = '0;
                    if (bit_r == 3'd7) begin
                        tx_s    = 1'b1;
                        state_s = ST_STOP;
                    end else begin
                        // Byte shifts right so the next data bit is always at [1].
                        bit_s  = bit_r + 3'd1;
                        tx_s   = byte_r[1];
                        byte_s = {1'b0, byte_r[7:1]};
                    end
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = '0;
                    if (char_r == 4'd11) begin
                        char_s  = 4'd0;
                        tx_s    = 1'b1;
                        busy_s  = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        // No idle gap: the next start bit begins right after this stop bit.
                        char_s  = char_r + 4'd1;
                        word_s  = word_shift_s;
                        byte_s  = char_byte(char_r + 4'd1, word_shift_s);
                        tx_s    = 1'b0;
                        state_s = ST_START;
                    end
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                bit_s   = 3'd0;
                char_s  = 4'd0;
                tx_s    = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_meas_hex_uart.sv
// Testbench for meas_hex_uart: UART monitor decodes characters and compares
// them against a queue of expected bytes pushed when each line is issued.
module tb_meas_hex_uart;

    logic        clk;
    logic        rst;
    logic [39:0] data;
    logic        data_valid;
    logic        tx;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    meas_hex_uart #(
        .CLK_FREQ(10),
        .BAUD    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .data_valid(data_valid),
        .tx        (tx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: ten uppercase hex digits, MSB first, then CR LF.
    function automatic void push_line(input logic [39:0] v);
        for (int k = 0; k < 10; k++) begin
            int nib;
            nib = int'((v >> (36 - 4 * k)) & 40'hF);
            if (nib < 10) exp_q.push_back(8'(48 + nib));
            else          exp_q.push_back(8'(65 + nib - 10));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // Caller is at a negedge. Issues one request and follows the line until busy drops.
    task automatic run_line(input logic [39:0] v, input bit inject);
        int m;
        int n_busy;
        data       = v;
        data_valid = 1'b1;
        push_line(v);
        @(negedge clk);
        data_valid = 1'b0;
        check("accept_tx_low", 64'(tx), 64'd0);
        check("accept_busy_high", 64'(busy), 64'd1);
        m = 0;
        n_busy = 0;
        while (busy === 1'b1 && n_busy < 1500) begin
            n_busy++;
            if (inject) begin
                data       = 40'h0;
                data_valid = (m + 1 == 5) || (m + 1 == 600) || (m + 1 == 1199) || (m + 1 == 1200);
            end
            @(negedge clk);
            m++;
        end
        data_valid = 1'b0;
        check("busy_length", 64'(n_busy), 64'd1200);
        check("tx_high_at_busy_fall", 64'(tx), 64'd1);
    endtask

    // Line must stay idle for n cycles.
    task automatic idle_check(input int n, input string name);
        bit ok;
        ok = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) ok = 1'b0;
        end
        check(name, 64'(ok), 64'd1);
    endtask

    // Monitor: on a falling tx, sample 100 cycles (10 bits x 10 clocks) and decode.
    initial begin : monitor
        logic samp [100];
        logic [7:0] rx;
        logic [7:0] ev;
        bit aborted;
        bit stable;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                aborted = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    if (i != 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[i] = tx;
                end
                if (!aborted) begin
                    stable = 1'b1;
                    for (int b = 0; b < 10; b++)
                        for (int s = 1; s < 10; s++)
                            if (samp[b * 10 + s] !== samp[b * 10]) stable = 1'b0;
                    for (int j = 0; j < 8; j++) rx[j] = samp[(j + 1) * 10];
                    check("start_bit", 64'(samp[0]), 64'd0);
                    check("stop_bit", 64'(samp[90]), 64'd1);
                    check("bit_timing", 64'(stable), 64'd1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_char: got %02h, expected none", rx);
                    end else begin
                        ev = exp_q.pop_front();
                        check("char", 64'(rx), 64'(ev));
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [63:0] rnd;
        rst        = 1'b1;
        data       = 40'h0;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);

        // Asynchronous reset between edges while idle.
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", 64'(tx), 64'd1);
        check("async_rst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_check(20, "idle_after_reset");

        // Basic line.
        run_line(40'h00_1234_ABCD, 1'b0);
        idle_check(20, "idle_after_basic");

        // Requests during transmission (incl. the busy-falling cycle) are ignored.
        run_line(40'hFF_FFFF_FFFF, 1'b1);
        idle_check(300, "no_second_line");

        // Back-to-back: second request on the first cycle busy is low.
        run_line(40'h0, 1'b0);
        rnd = {$urandom, $urandom};
        run_line(rnd[39:0], 1'b0);
        idle_check(20, "idle_after_b2b");

        // Reset in the middle of a line.
        rnd = {$urandom, $urandom};
        data       = rnd[39:0];
        data_valid = 1'b1;
        push_line(rnd[39:0]);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (437) @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("midframe_rst_tx", 64'(tx), 64'd1);
        check("midframe_rst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_check(20, "no_resume_after_reset");
        rnd = {$urandom, $urandom};
        run_line(rnd[39:0], 1'b0);
        idle_check(10, "idle_after_recovery");

        // Digit mapping boundaries 9/A and 0/F.
        run_line(40'h9A_0F_F0_A9_90, 1'b0);

        // Random words with random idle gaps.
        for (int t = 0; t < 4; t++) begin
            idle_check(int'($urandom_range(1, 40)), "idle_gap");
            rnd = {$urandom, $urandom};
            run_line(rnd[39:0], 1'b0);
        end

        idle_check(30, "final_idle");
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
